// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR request arbiter: command kinds and scheduler states.
// Optional read-priority build is selected with ARB_RD_PRIO_EN.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        RD_R  = 2'd0,
        WR_R  = 2'd1,
        RDA_R = 2'd2,
        WRA_R = 2'd3
    } request_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BLANK = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    function automatic logic is_read(request_t t);
        return (t == RD_R) || (t == RDA_R);
    endfunction

endpackage

// File: rtl/ddr_req_arbiter_if.sv
// Requester/controller-side bundle of the arbiter; master = requesters + controller, slave = arbiter.
interface ddr_req_arbiter_if
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 40
) ();

    logic     [NUM_REQ-1:0]             req_valid;
    request_t [NUM_REQ-1:0]             req_type;
    logic     [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic     [NUM_REQ-1:0]             req_ready;
    logic                               busy;
    logic                               refresh_rdy;
    logic                               cmd_rdy;
    logic     [ADDR_W-1:0]              log_addr;
    request_t                           request;
    logic     [$clog2(NUM_REQ)-1:0]     grant_id;

    modport master (
        output req_valid, req_type, req_addr, busy, refresh_rdy,
        input  req_ready, cmd_rdy, log_addr, request, grant_id
    );

    modport slave (
        input  req_valid, req_type, req_addr, busy, refresh_rdy,
        output req_ready, cmd_rdy, log_addr, request, grant_id
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first set bit of mask_i searching upward from ptr_i+1 with wrap.
module arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         mask_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       found_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] pos;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = IW'((32'(ptr_i) + k) % NUM_REQ);
            if (!found_o && mask_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Round-robin scheduler for the controller command port: grant, one-cycle cmd_rdy, blank, wait for idle.
// Define ARB_RD_PRIO_EN for read-over-write priority with write starvation bound WR_STARVE.
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 40,
    parameter int unsigned BUSY_BLANK = 2,
    parameter int unsigned WR_STARVE  = 4
) (
    input  logic              CK_t,
    input  logic              reset_n,
    ddr_req_arbiter_if.slave  bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = (BUSY_BLANK > 1) ? $clog2(BUSY_BLANK) : 1;

    arb_state_t           state_q;
    logic                 cmd_rdy_q;
    logic [ADDR_W-1:0]    addr_q;
    request_t             type_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [BW-1:0]        blank_q;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic                 grant;
    logic [NUM_REQ-1:0]   req_ready_c;

`ifdef ARB_RD_PRIO_EN
    localparam int unsigned SW = $clog2(WR_STARVE + 1);

    logic [NUM_REQ-1:0] rd_mask;
    logic [NUM_REQ-1:0] wr_mask;
    logic               rd_found;
    logic               wr_found;
    logic [IW-1:0]      rd_idx;
    logic [IW-1:0]      wr_idx;
    logic               pick_wr;
    logic [SW-1:0]      wr_wait_q;
    logic [SW-1:0]      wr_wait_d;

    always_comb begin
        rd_mask = '0;
        wr_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rd_mask[i] = bus.req_valid[i] &&  is_read(bus.req_type[i]);
            wr_mask[i] = bus.req_valid[i] && !is_read(bus.req_type[i]);
        end
    end

    arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_rd (
        .mask_i  (rd_mask),
        .ptr_i   (rr_ptr_q),
        .found_o (rd_found),
        .idx_o   (rd_idx)
    );

    arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_wr (
        .mask_i  (wr_mask),
        .ptr_i   (rr_ptr_q),
        .found_o (wr_found),
        .idx_o   (wr_idx)
    );

    // A starved write overrides read priority; otherwise writes only fill read-free slots.
    always_comb begin
        pick_wr   = wr_found && ((wr_wait_q == SW'(WR_STARVE)) || !rd_found);
        win_found = pick_wr ? wr_found : rd_found;
        win_idx   = pick_wr ? wr_idx   : rd_idx;
        wr_wait_d = wr_wait_q;
        if (!wr_found) begin
            wr_wait_d = '0;
        end else if (grant) begin
            if (pick_wr) begin
                wr_wait_d = '0;
            end else if (wr_wait_q != SW'(WR_STARVE)) begin
                wr_wait_d = wr_wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            wr_wait_q <= '0;
        end else begin
            wr_wait_q <= wr_wait_d;
        end
    end
`else
    arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .mask_i  (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (win_found),
        .idx_o   (win_idx)
    );
`endif

    assign grant = (state_q == IDLE) && win_found && !bus.busy && !bus.refresh_rdy;

    always_comb begin
        req_ready_c = '0;
        if (grant) begin
            req_ready_c[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_rdy_q <= 1'b0;
            addr_q    <= '0;
            type_q    <= RD_R;
            grant_q   <= '0;
            rr_ptr_q  <= IW'(NUM_REQ - 1);
            blank_q   <= '0;
        end else begin
            cmd_rdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q   <= ISSUE;
                        cmd_rdy_q <= 1'b1;
                        addr_q    <= bus.req_addr[win_idx];
                        type_q    <= bus.req_type[win_idx];
                        grant_q   <= win_idx;
                        rr_ptr_q  <= win_idx;
                    end
                end
                ISSUE: begin
                    blank_q <= '0;
                    state_q <= (BUSY_BLANK == 0) ? WAIT : BLANK;
                end
                BLANK: begin
                    // busy is not trusted until the controller has had time to raise it
                    if (blank_q == BW'(BUSY_BLANK - 1)) begin
                        state_q <= WAIT;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (!bus.busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.log_addr  = addr_q;
    assign bus.request   = type_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter; read-priority steps run only with ARB_RD_PRIO_EN.
module tb_ddr_req_arbiter;
    import ddr_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 40;

    logic CK_t;
    logic reset_n;

    ddr_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus_if ();

    ddr_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .BUSY_BLANK (2),
        .WR_STARVE  (2)
    ) dut (
        .CK_t    (CK_t),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    int checks = 0;
    int errors = 0;
    int busy_left = 0;
    bit bm_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; busy model raises busy for 3 cycles after each cmd_rdy.
    task automatic cyc();
        @(posedge CK_t);
        #1;
        if (bm_en) begin
            bus_if.busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (bus_if.cmd_rdy === 1'b1) busy_left = 3;
        end
    endtask

    task automatic clear_inputs();
        bus_if.req_valid   = '0;
        bus_if.busy        = 1'b0;
        bus_if.refresh_rdy = 1'b0;
        bm_en              = 1'b0;
        busy_left          = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    int unsigned exp_rr [5] = '{0, 1, 2, 3, 0};
    int n;
    int last;

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus_if.req_type[i] = RD_R;
            bus_if.req_addr[i] = ADDR_W'(40'h100 + i);
        end

        // 1. reset values
        cyc();
        cyc();
        #1;
        chk("rst_cmd_rdy",   64'(bus_if.cmd_rdy),   64'd0);
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        chk("rst_grant_id",  64'(bus_if.grant_id),  64'd0);
        chk("rst_log_addr",  64'(bus_if.log_addr),  64'd0);
        chk("rst_request",   64'(bus_if.request),   64'(RD_R));
        reset_n = 1'b1;

        // 2. single request
        bus_if.req_type[1] = WRA_R;
        bus_if.req_addr[1] = 40'h17FD5;
        bus_if.req_valid   = 4'b0010;
        #1;
        chk("single_req_ready", 64'(bus_if.req_ready), 64'b0010);
        chk("single_cmd_t",     64'(bus_if.cmd_rdy),   64'd0);
        cyc();
        bus_if.req_valid = '0;
        #1;
        chk("single_cmd_t1",  64'(bus_if.cmd_rdy),   64'd1);
        chk("single_addr",    64'(bus_if.log_addr),  64'h17FD5);
        chk("single_request", 64'(bus_if.request),   64'(WRA_R));
        chk("single_grant",   64'(bus_if.grant_id),  64'd1);
        chk("single_rdy_t1",  64'(bus_if.req_ready), 64'd0);
        cyc();
        #1;
        chk("single_cmd_t2",  64'(bus_if.cmd_rdy),  64'd0);
        chk("single_hold",    64'(bus_if.log_addr), 64'h17FD5);
        bus_if.req_type[1] = RD_R;
        bus_if.req_addr[1] = 40'h101;

        // 3. round-robin with all requesters valid
        do_reset();
        bus_if.req_valid = '1;
        bm_en = 1'b1;
        n = 0;
        last = -100;
        for (int c = 0; c < 80 && n < 5; c++) begin
            cyc();
            #1;
            if (bus_if.cmd_rdy === 1'b1) begin
                chk("rr_order", 64'(bus_if.grant_id), 64'(exp_rr[n]));
                chk("rr_addr",  64'(bus_if.log_addr), 64'(40'h100 + exp_rr[n]));
                if (n > 0) chk("rr_spacing", 64'((c - last) >= 5), 64'd1);
                last = c;
                n++;
            end
        end
        chk("rr_count", 64'(n), 64'd5);
        bus_if.req_valid = '0;
        bm_en = 1'b0;
        bus_if.busy = 1'b0;
        repeat (8) cyc();

        // 4. busy and refresh blocking; rr_ptr now 0, only req2 valid
        bus_if.busy = 1'b1;
        bus_if.req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_block_rdy", 64'(bus_if.req_ready), 64'd0);
            chk("busy_block_cmd", 64'(bus_if.cmd_rdy),   64'd0);
            cyc();
        end
        bus_if.busy = 1'b0;
        bus_if.refresh_rdy = 1'b1;
        #1;
        chk("refresh_block_rdy", 64'(bus_if.req_ready), 64'd0);
        cyc();
        #1;
        chk("refresh_block_cmd", 64'(bus_if.cmd_rdy), 64'd0);
        bus_if.refresh_rdy = 1'b0;
        #1;
        chk("unblock_rdy", 64'(bus_if.req_ready), 64'b0100);
        cyc();
        bus_if.req_valid = '0;
        bus_if.busy = 1'b1;
        #1;
        chk("unblock_cmd",   64'(bus_if.cmd_rdy),  64'd1);
        chk("unblock_grant", 64'(bus_if.grant_id), 64'd2);

        // 5. reset while waiting on busy
        repeat (3) cyc();
        #1;
        chk("wait_no_cmd", 64'(bus_if.cmd_rdy), 64'd0);
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        bus_if.busy = 1'b0;
        bus_if.req_valid = 4'b1001;
        #1;
        chk("rstwait_cmd",   64'(bus_if.cmd_rdy),   64'd0);
        chk("rstwait_grant", 64'(bus_if.grant_id),  64'd0);
        chk("rstwait_rdy",   64'(bus_if.req_ready), 64'b0001);
        cyc();
        bus_if.req_valid = 4'b1000;
        #1;
        chk("rstwait_cmd1",   64'(bus_if.cmd_rdy),  64'd1);
        chk("rstwait_grant1", 64'(bus_if.grant_id), 64'd0);
        bus_if.req_valid = '0;
        repeat (6) cyc();

`ifdef ARB_RD_PRIO_EN
        // 6. read priority with write starvation bound of 2
        begin
            request_t exp_ty [6] = '{RD_R, RD_R, WR_R, RD_R, RD_R, WR_R};
            do_reset();
            bus_if.req_type[0] = RD_R;
            bus_if.req_type[1] = WR_R;
            bus_if.req_valid = 4'b0011;
            n = 0;
            for (int c = 0; c < 80 && n < 6; c++) begin
                cyc();
                #1;
                if (bus_if.cmd_rdy === 1'b1) begin
                    chk("prio_type", 64'(bus_if.request), 64'(exp_ty[n]));
                    n++;
                end
            end
            chk("prio_count", 64'(n), 64'd6);
            bus_if.req_valid = '0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
